// File: rtl/bitbrick_pkg.sv
// Shared definitions for the sequential BitBrick multiplier: precision codes,
// controller states and digit-count helpers.
package bitbrick_pkg;

    localparam int ACC_W = 16;

    localparam logic [1:0] PREC_2B = 2'b00;
    localparam logic [1:0] PREC_4B = 2'b01;
    localparam logic [1:0] PREC_8B = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Number of 2-bit digits per operand; the reserved code behaves as 8-bit.
    function automatic logic [2:0] digit_count(input logic [1:0] prec);
        case (prec)
            PREC_2B: digit_count = 3'd1;
            PREC_4B: digit_count = 3'd2;
            default: digit_count = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] operand_mask(input logic [1:0] prec);
        case (prec)
            PREC_2B: operand_mask = 8'h03;
            PREC_4B: operand_mask = 8'h0F;
            default: operand_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/bitbrick_seq_mul_mul3b3b.sv
// BitBrick: 3b x 3b signed multiplier; a 2-bit digit plus its sign-extension bit.
module bitbrick_seq_mul_mul3b3b (
    input  logic signed [2:0] x_i,
    input  logic signed [2:0] y_i,
    output logic signed [5:0] p_o
);

    assign p_o = x_i * y_i;

endmodule

// File: rtl/bitbrick_seq_mul.sv
// Sequential precision-scalable multiplier: one BitBrick swept over digit pairs.
// Optional macro BITBRICK_SEQ_ZERO_BYPASS_EN skips RUN when a masked operand is zero.
module bitbrick_seq_mul
    import bitbrick_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic [1:0]       prec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result
);

    state_t           state_q, state_d;
    logic [7:0]       a_q, a_d, b_q, b_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [1:0]       prec_q, prec_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    logic [2:0]        n_dig;
    logic [1:0]        i_dig, j_dig, top_dig;
    logic [3:0]        cnt_last;
    logic [1:0]        x_dig, y_dig;
    logic signed [2:0] x3, y3;
    logic signed [5:0] prod;
    logic [2:0]        dig_sum;
    logic [ACC_W-1:0]  pp_shifted;

    always_comb begin
        n_dig    = digit_count(prec_q);
        top_dig  = n_dig[1:0] - 2'd1;
        // 4*4 wraps to 0 in four bits, so the subtraction still yields 15.
        cnt_last = {1'b0, n_dig} * {1'b0, n_dig} - 4'd1;
        case (prec_q)
            PREC_2B: begin
                i_dig = 2'd0;
                j_dig = 2'd0;
            end
            PREC_4B: begin
                i_dig = {1'b0, cnt_q[0]};
                j_dig = {1'b0, cnt_q[1]};
            end
            default: begin
                i_dig = cnt_q[1:0];
                j_dig = cnt_q[3:2];
            end
        endcase
        x_dig      = a_q[{i_dig, 1'b0} +: 2];
        y_dig      = b_q[{j_dig, 1'b0} +: 2];
        x3         = {sa_q && (i_dig == top_dig) && x_dig[1], x_dig};
        y3         = {sb_q && (j_dig == top_dig) && y_dig[1], y_dig};
        dig_sum    = {1'b0, i_dig} + {1'b0, j_dig};
        pp_shifted = {{(ACC_W-6){prod[5]}}, prod} << {dig_sum, 1'b0};
    end

    bitbrick_seq_mul_mul3b3b u_brick (
        .x_i (x3),
        .y_i (y3),
        .p_o (prod)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        prec_d  = prec_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d    = a;
                    b_d    = b;
                    sa_d   = sign_a;
                    sb_d   = sign_b;
                    prec_d = prec;
                    cnt_d  = '0;
                    acc_d  = '0;
`ifdef BITBRICK_SEQ_ZERO_BYPASS_EN
                    if (((a & operand_mask(prec)) == 8'h00) ||
                        ((b & operand_mask(prec)) == 8'h00))
                        state_d = DONE;
                    else
                        state_d = RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                acc_d = acc_q + pp_shifted;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == cnt_last)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            prec_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            prec_q  <= prec_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = acc_q;

endmodule
